// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Turns the PLL's "not locked" reset into clean per-domain resets.
//   Every rst_out bit asserts asynchronously with reset, releases
//   synchronously after a settle hold, and the domains come out of reset one
//   at a time (domain 0 first, STAGE_GAP cycles apart). ready goes high one
//   edge after the last domain is released. soft_rst restarts the settle hold
//   without re-running the reset synchronizer.
//
//   Optional watchdog: compile with RST_SEQ_WDOG_EN defined. Once all
//   domains are running, WDOG_CYCLES edges without a kick cause a restart
//   identical to a one-cycle soft_rst and set the sticky wdog_fired flag.
//   Without the macro, kick is ignored and wdog_fired is tied low.
//
// Ports
//   clk         PLL output clock (50 MHz)
//   reset       asynchronous active-high reset (inverted PLL lock)
//   soft_rst    synchronous software reset request, active-high
//   kick        watchdog kick (pulse or level), watchdog builds only
//   rst_out     per-domain active-high resets, NUM_DOMAINS wide
//   ready       all domains released
//   wdog_fired  sticky watchdog timeout flag, cleared only by reset
module rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1000,
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_GAP   = 16,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_rst,
  input  logic                   kick,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic                   wdog_fired
);

  // Parameter sanity, caught at elaboration.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_sequencer: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("rst_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_chk_dom
    $error("rst_sequencer: NUM_DOMAINS must be in 1..8");
  end
  if (STAGE_GAP < 1) begin : g_chk_gap
    $error("rst_sequencer: STAGE_GAP must be >= 1");
  end

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_HOLD  = 2'd1,
    S_STAGE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t          state;
  logic [SYNC_STAGES-1:0] sync;
  logic            sync_out;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   idx;
  logic            wd_expire;
  logic            restart;

  // Reset-release synchronizer: cleared asynchronously, fills with ones
  // once reset is low. soft_rst deliberately does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out = sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
`ifdef RST_SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wd_cnt;

  // Expiry on the edge the counter would reach WDOG_CYCLES; a kick on that
  // same edge wins.
  assign wd_expire = (state == S_RUN) && !kick && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt     <= '0;
      wdog_fired <= 1'b0;
    end else if (wd_expire) begin
      wd_cnt     <= '0;
      wdog_fired <= 1'b1;
    end else if (state != S_RUN || kick || soft_rst) begin
      wd_cnt     <= '0;
    end else begin
      wd_cnt     <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire  = 1'b0;
  assign wdog_fired = 1'b0;

  logic unused_kick;
  assign unused_kick = kick;
`endif

  // soft_rst and watchdog expiry are the same event; both on one edge is
  // just one restart.
  assign restart = soft_rst | wd_expire;

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  // hold_cnt counts settle edges already elapsed since T0, where T0 is the
  // edge the synchronizer output (or the last soft_rst sample) goes high.
  // From power-up the FSM sees sync_out one edge after T0, so that first
  // edge out of S_SYNC is itself the first settle edge; from soft_rst the
  // FSM is already in S_HOLD at T0. Both paths then release domain 0 on
  // edge T0 + HOLD_CYCLES with a single comparator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_SYNC;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      idx      <= '0;
      rst_out  <= '1;
      ready    <= 1'b0;
    end else if (restart) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      idx      <= '0;
      rst_out  <= '1;
      ready    <= 1'b0;
    end else begin
      case (state)
        S_SYNC, S_HOLD: begin
          if (state == S_HOLD || sync_out) begin
            if (hold_cnt == HOLD_LAST) begin
              rst_out[0] <= 1'b0;
              gap_cnt    <= '0;
              idx        <= IW'(1);
              state      <= (NUM_DOMAINS == 1) ? S_RUN : S_STAGE;
            end else begin
              hold_cnt   <= hold_cnt + 1'b1;
              state      <= S_HOLD;
            end
          end
        end

        S_STAGE: begin
          if (gap_cnt == GAP_LAST) begin
            // Decode instead of a variable index so idx can be wider than
            // the select needs for any NUM_DOMAINS.
            for (int i = 1; i < NUM_DOMAINS; i++) begin
              if (idx == IW'(i)) rst_out[i] <= 1'b0;
            end
            gap_cnt <= '0;
            idx     <= idx + 1'b1;
            if (idx == IDX_LAST) state <= S_RUN;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_RUN: begin
          // Registered: rises one edge after the last domain released.
          ready <= 1'b1;
        end

        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
//   Drives power-up, async reset glitches, soft_rst (including mid-sequence)
//   and, in watchdog builds, kick patterns. A reference model predicts every
//   output purely from the release time T0 of the current sequence:
//   rst_out[i] is high before edge T0 + HOLD + i*GAP and ready is high from
//   edge T0 + HOLD + (N-1)*GAP + 1. A second instance covers the
//   NUM_DOMAINS = 1, HOLD_CYCLES = 1 corner.
module tb_rst_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 1000;
  localparam int N    = 3;
  localparam int GAP  = 16;
  localparam int WDOG = 100;
  localparam longint NEVER = 64'sd1 << 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       soft_rst = 1'b0;
  logic       kick = 1'b0;
  logic [N-1:0] rst_out;
  logic       ready, wdog_fired;
  logic [0:0] rst_out_c;
  logic       ready_c, wdog_fired_c;

  always #10 clk = ~clk;

  rst_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .NUM_DOMAINS(N),
    .STAGE_GAP(GAP), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .kick(kick),
    .rst_out(rst_out), .ready(ready), .wdog_fired(wdog_fired)
  );

  rst_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(1), .NUM_DOMAINS(1),
    .STAGE_GAP(GAP), .WDOG_CYCLES(65536)
  ) dut_c (
    .clk(clk), .reset(reset), .soft_rst(soft_rst), .kick(kick),
    .rst_out(rst_out_c), .ready(ready_c), .wdog_fired(wdog_fired_c)
  );

  int     tests = 0;
  int     fails = 0;
  longint e = 0;            // posedge count
  longint t0 = NEVER;       // release reference, main instance
  longint t0c = NEVER;      // release reference, corner instance
  longint anchor = NEVER;   // last watchdog clear edge while running
  bit     fired = 1'b0;

  function automatic logic [N-1:0] exp_rst(longint ee, longint t);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (ee < t + HOLD + i * GAP);
    return v;
  endfunction

  function automatic logic exp_ready(longint ee, longint t);
    return ee >= t + HOLD + (N - 1) * GAP + 1;
  endfunction

  function automatic longint run_edge(longint t);
    return t + HOLD + (N - 1) * GAP;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rst_out"},   32'(rst_out),    32'(exp_rst(e, t0)));
    check({tag, ".ready"},     32'(ready),      32'(exp_ready(e, t0)));
    check({tag, ".wdog"},      32'(wdog_fired), 32'(fired));
    check({tag, ".rst_out_c"}, 32'(rst_out_c),  32'(e < t0c + 1));
    check({tag, ".ready_c"},   32'(ready_c),    32'(e >= t0c + 2));
  endtask

  // One clock edge: update the model from the inputs that edge sampled,
  // then compare all outputs 1 ns later.
  task automatic step();
    logic s, k;
    longint r;
    s = soft_rst;
    k = kick;
    @(posedge clk);
    e++;
    if (!reset) begin
      r = run_edge(t0);
      if (s) begin
        t0 = e; t0c = e; anchor = run_edge(e);
      end
`ifdef RST_SEQ_WDOG_EN
      else if (e > r) begin
        if (k) anchor = e;
        else if (e == anchor + WDOG) begin
          t0 = e; anchor = run_edge(e); fired = 1'b1;
        end
      end
`endif
    end
    #1;
    check_all("edge");
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called 1 ns after an edge; reset falls before the next edge.
  task automatic release_reset();
    reset = 1'b0;
    t0 = e + SYNC; t0c = e + SYNC; anchor = run_edge(e + SYNC);
  endtask

  // Short reset pulse between edges; outputs must react without a clock.
  task automatic glitch();
    #($urandom_range(2, 6));
    reset = 1'b1;
    t0 = NEVER; t0c = NEVER; anchor = NEVER; fired = 1'b0;
    #1;
    check_all("async");
    #1;
    release_reset();
  endtask

  longint base, last_soft;
  longint fall[N];
  longint rdy_at, fall_c, rdy_c;
  int     len;

  initial begin
    // ---- 1. power-up with defaults
    steps(5);
    release_reset();
    base = e;
    for (int i = 0; i < N; i++) fall[i] = -1;
    rdy_at = -1; fall_c = -1; rdy_c = -1;
    for (int n = 0; n < 1040; n++) begin
      step();
      for (int i = 0; i < N; i++)
        if (fall[i] < 0 && !rst_out[i]) fall[i] = e - base;
      if (rdy_at < 0 && ready)       rdy_at = e - base;
      if (fall_c < 0 && !rst_out_c[0]) fall_c = e - base;
      if (rdy_c < 0 && ready_c)      rdy_c = e - base;
    end
    check("pwr.fall0", 32'(fall[0]), 32'd1002);
    check("pwr.fall1", 32'(fall[1]), 32'd1018);
    check("pwr.fall2", 32'(fall[2]), 32'd1034);
    check("pwr.ready", 32'(rdy_at),  32'd1035);
    check("corner.fall", 32'(fall_c), 32'd3);
    check("corner.ready", 32'(rdy_c), 32'd4);

    // ---- 2. async reset glitch while running, full rerun
    glitch();
    steps(1040);

    // ---- 3. soft_rst while running
    len = $urandom_range(1, 4);
    soft_rst = 1'b1;
    step();
    check("soft.first", 32'(rst_out), 32'h7);
    steps(len - 1);
    last_soft = e;
    soft_rst = 1'b0;
    for (int n = 0; n < 1100 && rst_out[0]; n++) step();
    check("soft.fall0", 32'(e - last_soft), 32'd1000);

    // ---- 4. soft_rst pulse 5 cycles after domain 0 releases
    steps(5);
    soft_rst = 1'b1;
    step();
    check("mid.reassert", 32'(rst_out[0]), 32'd1);
    soft_rst = 1'b0;
    steps(1040);

    // ---- 6. watchdog: kicks keep it quiet, then stop kicking
    for (int k = 0; k < 8; k++) begin
      steps($urandom_range(20, 60));
      kick = 1'b1;
      step();
      kick = 1'b0;
    end
    check("kick.ready", 32'(ready), 32'd1);
`ifdef RST_SEQ_WDOG_EN
    for (int n = 0; n < 150 && !wdog_fired; n++) step();
    check("wdog.fired", 32'(wdog_fired), 32'd1);
    check("wdog.rst", 32'(rst_out), 32'h7);
    steps(1100);
    check("wdog.sticky", 32'(wdog_fired), 32'd1);
`else
    steps(150);
    check("wdog.off", 32'(wdog_fired), 32'd0);
`endif

    // random soft_rst pulse during staging, then reset clears everything
    for (int n = 0; n < 1100 && rst_out[0]; n++) step();
    steps($urandom_range(1, 40));
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    steps(1040);
    glitch();
    steps(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
